// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS registers, byte FIFO, serial FSM.
// Pops the FIFO back-to-back so queued bytes leave with no idle gap between frames.
module mmio_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic        Tx
);
    localparam int unsigned AW          = $clog2(FIFO_DEPTH);
    localparam int unsigned CW          = AW + 1;
    localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;
    localparam logic [15:0] BIT_LAST    = 16'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic [15:0]     cnt;
    logic [7:0]      shift;
    logic [2:0]      bit_idx;
    logic            tx;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            overflow;

    logic            txdata_sel;
    logic            status_sel;
    logic            fifo_empty;
    logic            fifo_full;
    logic            bit_done;
    logic            pop;
    logic            wr_req;
    logic            push;
    logic            ovf_event;
    logic            ovf_clear;
    logic            busy;
    logic            unused_bits;

    assign unused_bits = ^{ALUResult[1:0], WriteData[31:8]};

    assign txdata_sel = (ALUResult[31:2] == BASE_ADDR[31:2]);
    assign status_sel = (ALUResult[31:2] == STATUS_ADDR[31:2]);

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_CNT);
    assign bit_done   = (cnt == '0);
    assign busy       = (state != IDLE);

    // A pop happens from IDLE or at the last cycle of STOP; a push to a full
    // FIFO rides on that pop instead of overflowing.
    assign pop       = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_done));
    assign wr_req    = MemWrite && txdata_sel;
    assign push      = wr_req && (!fifo_full || pop);
    assign ovf_event = wr_req && fifo_full && !pop;
    assign ovf_clear = MemWrite && status_sel && WriteData[3];

    assign Hit = txdata_sel || status_sel;
    assign Tx  = tx;

    always_comb begin
        ReadData = '0;
        if (status_sel) begin
            ReadData = {28'b0, overflow, fifo_empty, fifo_full, busy};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (ovf_event) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= WriteData[7:0];
        end
    end

    // Tx is registered: each branch loads the level of the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            shift   <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state <= START;
                        shift <= mem[rd_ptr];
                        cnt   <= BIT_LAST;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        cnt     <= BIT_LAST;
                        bit_idx <= '0;
                        tx      <= shift[0];
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cnt     <= BIT_LAST;
                        shift   <= {1'b0, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            tx <= shift[1];
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (pop) begin
                            state <= START;
                            shift <= mem[rd_ptr];
                            cnt   <= BIT_LAST;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8: register vector table,
// serial-line decoder feeding a byte scoreboard, and hand-written timing sequences.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] STAT = BASE + 32'd4;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Hit;
    logic        Tx;

    int passed = 0;
    int total  = 0;
    bit mon_en = 1'b1;
    logic [7:0] sb[$];

    mmio_uart_tx #(
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH(8),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .MemWrite(MemWrite),
        .ALUResult(ALUResult),
        .WriteData(WriteData),
        .ReadData(ReadData),
        .Hit(Hit),
        .Tx(Tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc_write(input logic [31:0] addr, input logic [31:0] data);
        MemWrite  = 1'b1;
        ALUResult = addr;
        WriteData = data;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
        ALUResult = STAT;
        WriteData = '0;
    endtask

    task automatic idle_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_status(input logic [31:0] exp, input string name);
        MemWrite  = 1'b0;
        ALUResult = STAT;
        @(negedge clk);
        check(name, ReadData, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic count_idle(input int n, output int gaps);
        gaps = 0;
        ALUResult = STAT;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!ReadData[0]) gaps++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input int max_cycles, input string name);
        int n;
        n = 0;
        ALUResult = STAT;
        while ((sb.size() != 0 || ReadData[0]) && n < max_cycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(n < max_cycles), 32'd1);
    endtask

    // Serial decoder: samples each bit mid-cell on negedges and scores the byte.
    initial begin : monitor
        logic [7:0] b;
        logic start_bit;
        logic stop_bit;
        forever begin
            @(negedge clk);
            if (mon_en && reset && Tx == 1'b0) begin
                repeat (2) @(negedge clk);
                start_bit = Tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = Tx;
                end
                repeat (4) @(negedge clk);
                stop_bit = Tx;
                @(negedge clk);
                check("rx_framing", {30'b0, start_bit, stop_bit}, 32'h1);
                if (sb.size() == 0) begin
                    check("rx_unexpected_byte", {24'b0, b}, 32'hFFFF_FFFF);
                end else begin
                    check("rx_byte", {24'b0, b}, {24'b0, sb.pop_front()});
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_hit;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[11];

    initial begin : stim
        int gaps;
        int lows;
        logic [7:0] pat;
        logic exp_tx;
        logic exp_busy;

        vecs[0]  = '{1'b0, STAT,                 32'h0,         1'b1, 32'h4};
        vecs[1]  = '{1'b0, BASE,                 32'h0,         1'b1, 32'h0};
        vecs[2]  = '{1'b1, BASE + 32'd8,         32'h41,        1'b0, 32'h0};
        vecs[3]  = '{1'b0, STAT,                 32'h0,         1'b1, 32'h4};
        vecs[4]  = '{1'b0, BASE + 32'd8,         32'h0,         1'b0, 32'h0};
        vecs[5]  = '{1'b0, BASE + 32'd7,         32'h0,         1'b1, 32'h4};
        vecs[6]  = '{1'b0, BASE + 32'd2,         32'h0,         1'b1, 32'h0};
        vecs[7]  = '{1'b1, STAT,                 32'hFFFF_FFF7, 1'b1, 32'h4};
        vecs[8]  = '{1'b0, BASE - 32'd4,         32'h0,         1'b0, 32'h0};
        vecs[9]  = '{1'b0, 32'h2000_0004,        32'h0,         1'b0, 32'h0};
        vecs[10] = '{1'b0, STAT,                 32'h0,         1'b1, 32'h4};

        reset     = 1'b1;
        MemWrite  = 1'b0;
        ALUResult = STAT;
        WriteData = '0;
        #2;
        reset = 1'b0;
        #1;
        check("reset_tx", {31'b0, Tx}, 32'h1);
        check("reset_status", ReadData, 32'h4);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Register decode table
        for (int i = 0; i < 11; i++) begin
            MemWrite  = vecs[i].we;
            ALUResult = vecs[i].addr;
            WriteData = vecs[i].wdata;
            @(negedge clk);
            check($sformatf("vec%0d_hit", i), {31'b0, Hit}, {31'b0, vecs[i].exp_hit});
            check($sformatf("vec%0d_rdata", i), ReadData, vecs[i].exp_rd);
            @(posedge clk);
            #1;
            MemWrite = 1'b0;
        end
        check("no_frame_from_decode", {31'b0, Tx}, 32'h1);

        // Single byte 0x55: exact waveform and busy window
        pat = 8'h55;
        sb.push_back(8'h55);
        cyc_write(BASE, 32'h55);
        for (int k = 0; k < 42; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= 4)       exp_tx = 1'b0;
            else if (k >= 5 && k <= 36) exp_tx = pat[(k - 5) / 4];
            else                        exp_tx = 1'b1;
            exp_busy = (k >= 1 && k <= 40);
            check($sformatf("wave_tx_%0d", k), {31'b0, Tx}, {31'b0, exp_tx});
            check($sformatf("wave_busy_%0d", k), {31'b0, ReadData[0]}, {31'b0, exp_busy});
            @(posedge clk);
            #1;
        end
        wait_drain(100, "drain_single");

        // Nine stores back-to-back, then a push on the exact STOP-end pop
        for (int i = 1; i <= 9; i++) begin
            sb.push_back(8'(i));
            cyc_write(BASE, 32'(i));
        end
        chk_status(32'h3, "nine_full_no_ovf");
        count_idle(30, gaps);
        chk_status(32'h3, "full_before_pop");
        sb.push_back(8'h0A);
        cyc_write(BASE, 32'h0A);
        chk_status(32'h3, "push_on_pop_accepted");
        count_idle(350, lows);
        check("no_idle_gap", 32'(gaps + lows), 32'h0);
        wait_drain(200, "drain_nine");
        chk_status(32'h4, "nine_done_status");

        // Ten stores: tenth dropped, sticky overflow, clear only via bit 3
        for (int i = 0; i < 10; i++) begin
            if (i < 9) sb.push_back(8'(8'h11 + i));
            cyc_write(BASE, 32'(8'h11 + i));
        end
        chk_status(32'hB, "ten_overflow");
        cyc_write(STAT, 32'hFFFF_FFF7);
        chk_status(32'hB, "ovf_kept_other_bits");
        cyc_write(STAT, 32'h8);
        chk_status(32'h3, "ovf_cleared");
        wait_drain(500, "drain_ten");
        chk_status(32'h4, "ten_done_status");

        // Reset in the middle of data bit 3 with three bytes queued
        mon_en = 1'b0;
        cyc_write(BASE, 32'hF0);
        cyc_write(BASE, 32'h01);
        cyc_write(BASE, 32'h02);
        cyc_write(BASE, 32'h03);
        repeat (14) idle_cyc();
        #2;
        check("pre_reset_tx_bit3", {31'b0, Tx}, 32'h0);
        check("pre_reset_status", ReadData, 32'h1);
        reset = 1'b0;
        #1;
        check("async_reset_tx", {31'b0, Tx}, 32'h1);
        check("async_reset_status", ReadData, 32'h4);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!Tx) lows++;
            @(posedge clk);
            #1;
        end
        check("tx_idle_after_reset", 32'(lows), 32'h0);
        chk_status(32'h4, "status_after_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, giving clk cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, giving transmit FIFO entries (power of two, 2..64).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h1000_0000, giving the word-aligned register base.
REQ-004 SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have the port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-006 SHALL have the port MemWrite, input, 1 bit: store strobe from the core, valid for one cycle per store.
REQ-007 SHALL have the port ALUResult, input, 32 bits: core data address.
REQ-008 SHALL have the port WriteData, input, 32 bits: core store data.
REQ-009 SHALL have the port ReadData, output, 32 bits: register readback; combinational from ALUResult and state.
REQ-010 SHALL have the port Hit, output, 1 bit: high when ALUResult is BASE_ADDR or BASE_ADDR+4, so the system mux selects ReadData.
REQ-011 SHALL have the port Tx, output, 1 bit: serial line, idle high.

Function
REQ-012 SHALL decode TXDATA at BASE_ADDR and STATUS at BASE_ADDR+4; ALUResult[1:0] is ignored; all other addresses give Hit=0 and ReadData=0.
REQ-013 SHALL push WriteData[7:0] into the FIFO on a cycle with MemWrite=1 at TXDATA when the FIFO is not full.
REQ-014 SHALL accept a push when the FIFO is full only if a pop occurs in the same cycle; occupancy is then unchanged.
REQ-015 SHALL drop any other push to a full FIFO, leaving FIFO contents unchanged, and set the sticky overflow flag.
REQ-016 SHALL return STATUS as {28'b0, overflow, empty, full, busy}: busy = FSM not IDLE; full/empty = FIFO occupancy equal to FIFO_DEPTH/0.
REQ-017 SHALL return 0 when TXDATA is read.
REQ-018 SHALL clear overflow on MemWrite=1 at STATUS with WriteData[3]=1; writes of other STATUS bits are ignored.
REQ-019 SHALL set overflow when a same-cycle overflow event and clear request coincide (set wins).
REQ-020 SHALL use FSM states IDLE, START, DATA, STOP.
REQ-021 SHALL, in IDLE with the FIFO non-empty, pop the head byte into an 8-bit shift register and enter START on the next edge.
REQ-022 SHALL drive Tx=1 in IDLE and STOP, Tx=0 in START, and Tx=shift[0] in DATA (LSB first).
REQ-023 SHALL hold each START, DATA and STOP bit for exactly CLKS_PER_BIT cycles, timed by a down-counter loaded with CLKS_PER_BIT-1 on state entry and on each bit.
REQ-024 SHALL shift right and advance a 3-bit bit index at the end of each DATA bit, entering STOP after bit index 7.
REQ-025 SHALL, at the end of STOP, pop and re-enter START if the FIFO is non-empty (no idle gap), else enter IDLE.
REQ-026 SHALL produce a frame of exactly 10*CLKS_PER_BIT cycles; Tx first falls one cycle after the push to an empty, idle block.
REQ-027 SHALL keep FIFO order strictly first-in first-out, with pointers wrapping modulo FIFO_DEPTH.

Reset
REQ-028 SHALL, while reset=0 and independent of clk, force: FSM=IDLE, Tx=1, FIFO empty (pointers and count 0), overflow=0, counter=0, shift register=0.
REQ-029 SHALL abandon any in-flight frame on mid-frame reset, with Tx high immediately; queued bytes are lost.
REQ-030 SHALL give ReadData STATUS = 32'h0000_0004 after reset.

Verification
REQ-031 SHALL cover: CLKS_PER_BIT=4, store 0x55 to TXDATA -> Tx = 0 for 4 cycles, then 1,0,1,0,1,0,1,0 for 4 cycles each, then 1 for 4 cycles; busy=1 for 40 cycles.
REQ-032 SHALL cover: nine back-to-back stores 0x01..0x09 with FIFO_DEPTH=8 while idle -> the first is popped immediately, all nine transmitted in order with no idle gap, overflow stays 0.
REQ-033 SHALL cover: ten stores while idle -> the tenth is dropped, STATUS reads 32'h0000_000B (overflow, full, busy); a STATUS write of 32'h8 then reads 32'h3.
REQ-034 SHALL cover: a push to a full FIFO on the exact cycle of the STOP-end pop -> accepted, full remains 1, overflow stays 0.
REQ-035 SHALL cover: reset asserted mid-DATA bit 3 with 3 bytes queued -> Tx=1 asynchronously; after release STATUS=32'h4 and Tx stays 1.
REQ-036 SHALL cover: a store to BASE_ADDR+8 and a load of BASE_ADDR -> no push, Hit=0 then 1, ReadData=0.
